// File: rtl/irq_mux_pkg.sv
// Shared constants for the interrupt concentrator: register map, defaults and
// ACTIVE field layout.
package irq_mux_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_MASK    = 3'd2;
  localparam logic [2:0] REG_MODE    = 3'd3;
  localparam logic [2:0] REG_ACTIVE  = 3'd4;
  localparam logic [2:0] REG_FORCE   = 3'd5;

  localparam int unsigned NSRC_DEFAULT        = 8;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  localparam int unsigned ACTIVE_VALID_RDATA_BIT = 7;
  localparam int unsigned ACTIVE_VALID_ID_BIT    = 3;

endpackage

// File: rtl/irq_mux_sync_edge.sv
// Per-source synchroniser chain plus previous-sample flop; flags the cycle in
// which the synchronised active-low request first goes low.
module sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_ni,
  output logic synced_no,
  output logic assert_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[Stages-2:0], src_ni};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign synced_no = sync_q[Stages-1];
  assign assert_o  = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/irq_mux.sv
// Interrupt concentrator: synchronises active-low sources, latches edge/level
// requests, masks, priority-encodes and drives a registered active-low irq.
module irq_mux
  import irq_mux_pkg::*;
#(
  parameter int unsigned NSRC        = NSRC_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            phi2,
  input  logic            cs,
  input  logic            rw,
  input  logic [2:0]      regsel,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata,
  input  logic [NSRC-1:0] src_n,
  output logic            irq,
  output logic [3:0]      active_id
);

  logic [NSRC-1:0] synced_n, assert_p;

  for (genvar i = 0; i < NSRC; i++) begin : g_sync
    sync_edge #(
      .Stages(SYNC_STAGES)
    ) u_sync (
      .clk_i    (clock),
      .rst_ni   (reset),
      .src_ni   (src_n[i]),
      .synced_no(synced_n[i]),
      .assert_o (assert_p[i])
    );
  end

  logic            phi2_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            irq_q, irq_d;
  logic [3:0]      active_id_q, active_id_d;

  // One commit per bus cycle: the clock edge that sees phi2 fall.
  logic commit;
  assign commit = phi2_q & ~phi2 & ~cs & ~rw;

  logic wr_pending, wr_mask, wr_mode, wr_force;
  assign wr_pending = commit && (regsel == REG_PENDING);
  assign wr_mask    = commit && (regsel == REG_MASK);
  assign wr_mode    = commit && (regsel == REG_MODE);
  assign wr_force   = commit && (regsel == REG_FORCE);

  logic [NSRC-1:0] wsrc, level_v, set_v, clr_v, edge_v, act_v;
  assign wsrc    = wdata[NSRC-1:0];
  assign level_v = ~synced_n;
  assign act_v   = pending_q & mask_q;

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_mask) mask_d = wsrc;
    if (wr_mode) mode_d = wsrc;

    set_v  = assert_p | (wr_force ? wsrc : '0);
    clr_v  = wr_pending ? wsrc : '0;
    edge_v = set_v | (pending_q & ~clr_v);

    pending_d = (mode_q & edge_v) | (~mode_q & level_v);
    // Switching a bit to edge mode starts it from a clean pending state.
    if (wr_mode) pending_d = pending_d & ~(wsrc & ~mode_q);
  end

  always_comb begin
    active_id_d = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (act_v[i]) active_id_d[2:0] = 3'(i);
    end
    active_id_d[ACTIVE_VALID_ID_BIT] = |act_v;
    irq_d = ~|act_v;
  end

  logic [7:0] status8, pend8, mask8, mode8;

  always_comb begin
    status8 = '0;
    pend8   = '0;
    mask8   = '0;
    mode8   = '0;
    status8[NSRC-1:0] = level_v;
    pend8[NSRC-1:0]   = pending_q;
    mask8[NSRC-1:0]   = mask_q;
    mode8[NSRC-1:0]   = mode_q;

    rdata_d = '0;
    if (!cs && rw) begin
      case (regsel)
        REG_STATUS:  rdata_d = status8;
        REG_PENDING: rdata_d = pend8;
        REG_MASK:    rdata_d = mask8;
        REG_MODE:    rdata_d = mode8;
        REG_ACTIVE: begin
          rdata_d[ACTIVE_VALID_RDATA_BIT] = active_id_q[ACTIVE_VALID_ID_BIT];
          rdata_d[2:0]                    = active_id_q[2:0];
        end
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      phi2_q      <= 1'b0;
      pending_q   <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b1;
      active_id_q <= '0;
    end else begin
      phi2_q      <= phi2;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      active_id_q <= active_id_d;
    end
  end

  assign rdata     = rdata_q;
  assign irq       = irq_q;
  assign active_id = active_id_q;

endmodule
